// File: rtl/period_generator_if.sv
// Handshake and output bundle of the period generator. The controller (master) drives
// start/stop/prd/num, and the generator (slave) returns the status flags and the wave.
interface period_generator_if #(
    parameter int W  = 10,
    parameter int NB = 8
);
    logic          start;
    logic          stop;
    logic [W-1:0]  prd;
    logic [NB-1:0] num;
    logic          ready;
    logic          so;
    logic          edge_tick;
    logic          done_tick;
    logic          err_tick;

    modport master (
        output start, stop, prd, num,
        input  ready, so, edge_tick, done_tick, err_tick
    );

    modport slave (
        input  start, stop, prd, num,
        output ready, so, edge_tick, done_tick, err_tick
    );
endinterface

// File: rtl/period_generator.sv
// Programmable square-wave source with a period of prd milliseconds. It runs either for
// a burst of num periods or continuously (num=0), and always completes the period in progress.
module period_generator #(
    parameter int DVSR = 100_000,
    parameter int W    = 10,
    parameter int NB   = 8
) (
    input  logic                clk,
    input  logic                reset,
    period_generator_if.slave   bus
);
    localparam int PW = (DVSR > 1) ? $clog2(DVSR) : 1;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t        state;
    logic [PW-1:0] ps_cnt;
    logic [W-1:0]  ms_cnt;
    logic [W-1:0]  p_reg;
    logic [NB-1:0] n_reg;
    logic [NB-1:0] c_reg;
    logic          stop_pend;

    logic          ms_tick;
    logic [W:0]    h_len;
    logic [W:0]    l_len;
    logic [W:0]    phase_len;
    logic          phase_end;
    logic [NB-1:0] c_next;
    logic          finish;

    // One extra bit keeps (p_reg+1) from overflowing when p_reg is at its maximum.
    assign ms_tick   = (ps_cnt == PW'(DVSR - 1));
    assign h_len     = ({1'b0, p_reg} + 1'b1) >> 1;
    assign l_len     = {1'b0, p_reg >> 1};
    assign phase_len = (state == HIGH) ? h_len : l_len;
    assign phase_end = ms_tick && (({1'b0, ms_cnt} + 1'b1) == phase_len);

    // The period counter saturates, so a long continuous run never wraps into a false done.
    assign c_next = (c_reg == '1) ? c_reg : c_reg + 1'b1;
    assign finish = ((n_reg != '0) && (c_next == n_reg)) || stop_pend || bus.stop;

    // NOTE: every register here is written with <= so all of them update together on the
    // clock edge; a blocking = would let later statements see half-updated state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ps_cnt        <= '0;
            ms_cnt        <= '0;
            p_reg         <= '0;
            n_reg         <= '0;
            c_reg         <= '0;
            stop_pend     <= 1'b0;
            bus.ready     <= 1'b1;
            bus.so        <= 1'b0;
            bus.edge_tick <= 1'b0;
            bus.done_tick <= 1'b0;
            bus.err_tick  <= 1'b0;
        end else begin
            bus.edge_tick <= 1'b0;
            bus.done_tick <= 1'b0;
            bus.err_tick  <= 1'b0;

            if (state != IDLE) begin
                ps_cnt <= ms_tick ? '0 : ps_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.prd >= W'(2)) begin
                            p_reg         <= bus.prd;
                            n_reg         <= bus.num;
                            c_reg         <= '0;
                            ps_cnt        <= '0;
                            ms_cnt        <= '0;
                            stop_pend     <= 1'b0;
                            state         <= HIGH;
                            bus.so        <= 1'b1;
                            bus.edge_tick <= 1'b1;
                            bus.ready     <= 1'b0;
                        end else begin
                            bus.err_tick  <= 1'b1;
                        end
                    end
                end

                HIGH: begin
                    if (bus.stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (phase_end) begin
                        ms_cnt <= '0;
                        state  <= LOW;
                        bus.so <= 1'b0;
                    end else if (ms_tick) begin
                        ms_cnt <= ms_cnt + 1'b1;
                    end
                end

                LOW: begin
                    if (bus.stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (phase_end) begin
                        ms_cnt <= '0;
                        c_reg  <= c_next;
                        if (finish) begin
                            state         <= IDLE;
                            bus.done_tick <= 1'b1;
                            bus.ready     <= 1'b1;
                        end else begin
                            state         <= HIGH;
                            bus.so        <= 1'b1;
                            bus.edge_tick <= 1'b1;
                        end
                    end else if (ms_tick) begin
                        ms_cnt <= ms_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
